// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak pi stage: lane indexing, rho offsets,
// legal lane widths and the skid-buffer state encoding.
// The rho table is referenced only when KECCAK_PI_RHO_EN is defined.
package keccak_pkg;

  localparam int unsigned NumLanes      = 25;
  localparam int unsigned NumLegalLaneW = 7;

  // Lane widths that correspond to the standard Keccak-f permutation sizes.
  localparam int unsigned LegalLaneW [NumLegalLaneW] = '{1, 2, 4, 8, 16, 32, 64};

  // Keccak rho rotation offsets for 64-bit lanes, indexed by idx(x, y) = 5y + x.
  // Narrower lanes use each offset modulo the lane width.
  localparam int unsigned RhoOffset [NumLanes] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  // Occupancy of the two-entry output skid buffer.
  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } buf_state_e;

  // Flat lane index of lane (x, y) within the state vector.
  function automatic int unsigned idx(input int unsigned x, input int unsigned y);
    return 5 * y + x;
  endfunction

  // True when w is one of the supported lane widths.
  function automatic bit lane_w_legal(input int unsigned w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NumLegalLaneW; i++) begin
      if (LegalLaneW[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/keccak_pi_map.sv
// Combinational Keccak lane permutation.
//   inv = 0 : A'[x,y] = A[(x+3y) mod 5, x]            (pi)
//   inv = 1 : A'[(x+3y) mod 5, x] = A[x,y]            (pi inverse)
// With KECCAK_PI_RHO_EN defined, forward mode rotates every lane left by its
// rho offset before pi, and inverse mode applies pi inverse followed by the
// matching right rotation, so the two modes stay exact inverses.
module keccak_pi_map
  import keccak_pkg::*;
#(
  parameter int unsigned LANE_W = 64
) (
  input  logic [25*LANE_W-1:0] state,
  input  logic                 inv,
  output logic [25*LANE_W-1:0] permuted
);

  logic [24:0][LANE_W-1:0] lane_in;
  logic [24:0][LANE_W-1:0] pre_fwd;   // forward input after optional rho
  logic [24:0][LANE_W-1:0] pi_fwd;
  logic [24:0][LANE_W-1:0] pi_inv;
  logic [24:0][LANE_W-1:0] post_inv;  // inverse result after optional rho undo

  assign lane_in = state;

`ifdef KECCAK_PI_RHO_EN
  // Rotations are fixed per lane, so each is pure wiring on a doubled lane.
  for (genvar k = 0; k < 25; k++) begin : g_rho
    localparam int unsigned Rot = RhoOffset[k] % LANE_W;
    logic [2*LANE_W-1:0] dbl_fwd;
    logic [2*LANE_W-1:0] dbl_inv;
    assign dbl_fwd    = {lane_in[k], lane_in[k]};
    assign dbl_inv    = {pi_inv[k], pi_inv[k]};
    assign pre_fwd[k]  = dbl_fwd[LANE_W-Rot +: LANE_W];
    assign post_inv[k] = dbl_inv[Rot +: LANE_W];
  end
`else
  assign pre_fwd  = lane_in;
  assign post_inv = pi_inv;
`endif

  // Each (x, y) pairs a destination with its pi source; the inverse swaps roles.
  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      localparam int unsigned Dst = idx(x, y);
      localparam int unsigned Src = idx((x + 3 * y) % 5, x);
      assign pi_fwd[Dst] = pre_fwd[Src];
      assign pi_inv[Src] = lane_in[Dst];
    end
  end

  assign permuted = inv ? post_inv : pi_fwd;

endmodule

// File: rtl/keccak_pi_stage.sv
// Registered Keccak pi / inverse-pi stage with a two-entry skid buffer.
// The permutation is computed on the input side and the result is stored,
// so out_data is always a register output. in_ready is registered and does
// not depend on out_ready; the second entry absorbs the transfer that may
// arrive while the downstream stalls. Optional rho is enabled with the
// KECCAK_PI_RHO_EN macro (handled inside keccak_pi_map).
module keccak_pi_stage
  import keccak_pkg::*;
#(
  parameter  int unsigned LANE_W  = 64,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned STATE_W = 25 * LANE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic [CNT_W-1:0]   xfer_cnt
);

  if (!lane_w_legal(LANE_W)) begin : g_lane_w_check
    $fatal(1, "keccak_pi_stage: LANE_W must be one of 1, 2, 4, 8, 16, 32, 64");
  end

  buf_state_e         state_q, state_d;
  logic               in_ready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [STATE_W-1:0] mapped;
  logic [STATE_W-1:0] entry0_q;  // oldest entry, always drives out_data
  logic [STATE_W-1:0] entry1_q;  // only meaningful in StFull
  logic               push;
  logic               pop;

  // in_inv travels with in_data, so the mode is chosen per transfer.
  keccak_pi_map #(
    .LANE_W (LANE_W)
  ) u_map (
    .state    (in_data),
    .inv      (in_inv),
    .permuted (mapped)
  );

  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // Buffer occupancy next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (push) state_d = StOne;
      end
      StOne: begin
        if (push && !pop)      state_d = StFull;
        else if (!push && pop) state_d = StEmpty;
      end
      StFull: begin
        if (pop) state_d = StOne;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Control state, registered ready and transfer counter; reset drops all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Entry storage is not reset; the occupancy state says what is valid.
  always_ff @(posedge clk) begin
    case (state_q)
      StEmpty: begin
        if (push) entry0_q <= mapped;
      end
      StOne: begin
        if (push && pop) entry0_q <= mapped;
        else if (push)   entry1_q <= mapped;
      end
      StFull: begin
        if (pop) entry0_q <= entry1_q;
      end
      default: ;
    endcase
  end

  assign in_ready = in_ready_q;
  assign out_data = entry0_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_keccak_pi_stage.sv
// Directed bench for keccak_pi_stage: three instances (64/16, 8/4, 1/16)
// share one handshake so round-trip and counter-wrap cases run in lock-step.
module tb_keccak_pi_stage;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_inv = 1'b0;
  logic          out_ready = 1'b0;

  logic [1599:0] in_data64 = '0;
  logic [199:0]  in_data8 = '0;
  logic [24:0]   in_data1 = '0;

  logic          in_ready64, in_ready8, in_ready1;
  logic          out_valid64, out_valid8, out_valid1;
  logic [1599:0] out_data64;
  logic [199:0]  out_data8;
  logic [24:0]   out_data1;
  logic [15:0]   cnt64;
  logic [3:0]    cnt8;
  logic [15:0]   cnt1;

  int checks = 0;
  int errors = 0;

  // Pi source lane for each destination lane, worked out by hand.
  int src_lane [25] = '{0, 6, 12, 18, 24, 3, 9, 10, 16, 22, 1, 7, 13, 19, 20,
                        4, 5, 11, 17, 23, 2, 8, 14, 15, 21};

  logic [1599:0] exp, exp036, r, f64, v0, v1, v2;
  logic [199:0]  f8;
  logic [24:0]   f1;
  int            pushes, pops, cyc, stalls;
  bit            seen_first, did17;

  keccak_pi_stage #(.LANE_W(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64), .in_inv(in_inv),
    .in_data(in_data64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .xfer_cnt(cnt64)
  );

  keccak_pi_stage #(.LANE_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .in_inv(in_inv),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .xfer_cnt(cnt8)
  );

  keccak_pi_stage #(.LANE_W(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_inv(in_inv),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .xfer_cnt(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1599:0] obs, input logic [1599:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", out_valid64, 1'b0);
    check("rst_in_ready", in_ready64, 1'b0);
    check("rst_cnt", cnt64, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", in_ready64, 1'b1);
    out_ready = 1'b1;

    // Single lane (1,1) moves to lane (1,0) one cycle after acceptance
    exp036 = '0;
`ifdef KECCAK_PI_RHO_EN
    exp036[1*64 +: 64] = 64'h34567DEADBEEF012;
`else
    exp036[1*64 +: 64] = 64'hDEADBEEF01234567;
`endif
    @(negedge clk);
    in_data64 = '0;
    in_data64[6*64 +: 64] = 64'hDEADBEEF01234567;
    in_inv = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("lane6_out_valid", out_valid64, 1'b1);
    check("lane6_out_data", out_data64, exp036);

`ifndef KECCAK_PI_RHO_EN
    // Every lane tagged with its own index: forward then inverse mode
    @(negedge clk);
    for (int k = 0; k < 25; k++) in_data64[k*64 +: 64] = 64'(k);
    in_inv = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) exp[k*64 +: 64] = 64'(src_lane[k]);
    check("pi_fwd_index", out_data64, exp);
    @(negedge clk);
    in_inv = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) exp[src_lane[k]*64 +: 64] = 64'(k);
    check("pi_inv_index", out_data64, exp);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drained", out_valid64, 1'b0);

    // Forward result fed back in inverse mode must restore the input
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int k = 0; k < 50; k++) r[k*32 +: 32] = $urandom();
      in_data64 = r;
      in_data8 = r[1599:1400];
      in_data1 = r[1374:1350];
      in_inv = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      f64 = out_data64;
      f8 = out_data8;
      f1 = out_data1;
      @(negedge clk);
      in_inv = 1'b1;
      in_data64 = f64;
      in_data8 = f8;
      in_data1 = f1;
      @(posedge clk); #1;
      check("roundtrip_w64", out_data64, r);
      check("roundtrip_w8", out_data8, r[1599:1400]);
      check("roundtrip_w1", out_data1, r[1374:1350]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_inv = 1'b0;
    @(posedge clk); #1;
    check("roundtrip_drained", {out_valid64, out_valid8, out_valid1}, 3'b000);

    // Backpressure: two accepted, third held, head stable, then FIFO drain
    v0 = '0; v0[63:0] = 64'h1111_2222_3333_4444;
    v1 = '0; v1[63:0] = 64'h5555_6666_7777_8888;
    v2 = '0; v2[63:0] = 64'h9999_AAAA_BBBB_CCCC;
    @(negedge clk);
    out_ready = 1'b0;
    in_data64 = v0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_1", in_ready64, 1'b1);
    @(negedge clk);
    in_data64 = v1;
    @(posedge clk); #1;
    check("bp_ready_after_2", in_ready64, 1'b0);
    check("bp_head_after_2", out_data64, v0);
    @(negedge clk);
    in_data64 = v2;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check("bp_ready_held", in_ready64, 1'b0);
      check("bp_head_stable", out_data64, v0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_order_1", out_data64, v1);
    check("bp_ready_reopen", in_ready64, 1'b1);
    @(posedge clk); #1;
    check("bp_order_2", out_data64, v2);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_empty", out_valid64, 1'b0);

    // Fresh reset, then 1000 back-to-back transfers
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pushes = 0; pops = 0; cyc = 0; stalls = 0; seen_first = 1'b0; did17 = 1'b0;
    for (int k = 0; k < 25; k++) in_data64[k*64 +: 64] = 64'(k + 100);
    while (pops < 1000 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (pops == 17 && !did17) begin
        did17 = 1'b1;
        check("cnt4_after_17", cnt8, 4'd1);
      end
      in_valid = (pushes < 1000);
      if (seen_first && !out_valid64) stalls++;
      if (out_valid64) seen_first = 1'b1;
      if (in_valid && in_ready64) pushes++;
      if (out_valid64 && out_ready) pops++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_pops", pops, 1000);
    check("stream_cycles", cyc, 1001);
    check("stream_stalls", stalls, 0);
    check("stream_cnt16", cnt64, 16'd1000);
    check("stream_cnt4", cnt8, 4'd8);
    check("stream_cnt16_w1", cnt1, 16'd1000);

    // Reset between edges while FULL
    @(negedge clk);
    out_ready = 1'b0;
    in_data64 = v0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data64 = v1;
    @(posedge clk); #1;
    check("full_before_reset", in_ready64, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid64, 1'b0);
    check("midrst_in_ready", in_ready64, 1'b0);
    check("midrst_cnt", cnt64, 16'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_data64 = '0;
    in_data64[6*64 +: 64] = 64'hDEADBEEF01234567;
    in_inv = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("postrst_ready", in_ready64, 1'b1);
    check("postrst_no_stale", out_valid64, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("postrst_first_valid", out_valid64, 1'b1);
    check("postrst_first_data", out_data64, exp036);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
